thinkgear_packet_parser: RTL



---
 rtl/thinkgear_packet_parser.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/thinkgear_packet_parser.sv
// thinkgear_packet_parser
//   Decodes the NeuroSky ThinkGear byte stream arriving from the UART
//   receiver. Each packet's sync, length and checksum are validated. Held
//   attention / meditation / poor-signal values are updated only when a
//   packet is accepted. After each accepted packet, one-cycle left/right
//   steering pulses are raised for the game logic.
//
// Ports
//   clk              system clock
//   rst              asynchronous active-high reset
//   rx_data[7:0]     received byte
//   rx_valid         rx_data valid this cycle
//   attention_data   last committed attention value (code 0x04)
//   meditation_data  last committed meditation value (code 0x05)
//   signal_data      last committed poor-signal value (code 0x02)
//   brain_left       one-cycle steering pulse, left
//   brain_right      one-cycle steering pulse, right
//   pkt_ok           one-cycle pulse, packet accepted
//   pkt_err          one-cycle pulse, packet discarded
//
// state   | meaning
// --------+----------------------------------------------------------
// SYNC1   | hunting for first 0xAA
// SYNC2   | expecting second 0xAA
// PLEN    | payload length (extra 0xAA tolerated)
// CODE    | row code byte (0x55 extended-code prefix skipped)
// VLEN    | value length of a multi-byte row (code >= 0x80)
// VALUE   | row value bytes
// CHK     | checksum byte, commit shadows on match

module thinkgear_packet_parser #(
   parameter logic [7:0] ATT_TH   = 8'd60,
   parameter logic [7:0] MED_TH   = 8'd60,
   parameter logic [7:0] SIG_GOOD = 8'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] attention_data,
   output logic [7:0] meditation_data,
   output logic [7:0] signal_data,
   output logic       brain_left,
   output logic       brain_right,
   output logic       pkt_ok,
   output logic       pkt_err
);

   typedef enum logic [2:0] {
      SYNC1, SYNC2, PLEN, CODE, VLEN, VALUE, CHK
   } state_t;

   state_t     state;
   logic [7:0] remaining;
   logic [7:0] vcount;
   logic [7:0] sum;
   logic [7:0] code;
   logic [7:0] sh_att, sh_med, sh_sig;
   logic       v_att, v_med, v_sig;

   logic [7:0] sum_next, rem_next, vcount_next;
   logic [7:0] att_commit, med_commit, sig_commit;
   logic       att_hit, med_hit, sig_good;
   logic       steer_right, steer_left;

   always_comb begin
      sum_next    = sum + rx_data;
      rem_next    = remaining - 8'd1;
      vcount_next = vcount - 8'd1;
      // Steering is judged on the values as they will stand after the commit.
      att_commit  = v_att ? sh_att : attention_data;
      med_commit  = v_med ? sh_med : meditation_data;
      sig_commit  = v_sig ? sh_sig : signal_data;
      att_hit     = (att_commit >= ATT_TH);
      med_hit     = (med_commit >= MED_TH);
      sig_good    = (sig_commit <= SIG_GOOD);
      steer_right = att_hit && sig_good && !med_hit;
      steer_left  = med_hit && sig_good && !att_hit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= SYNC1;
         remaining       <= 8'd0;
         vcount          <= 8'd0;
         sum             <= 8'd0;
         code            <= 8'd0;
         sh_att          <= 8'd0;
         sh_med          <= 8'd0;
         sh_sig          <= 8'd0;
         v_att           <= 1'b0;
         v_med           <= 1'b0;
         v_sig           <= 1'b0;
         attention_data  <= 8'd0;
         meditation_data <= 8'd0;
         signal_data     <= 8'hC8;
         brain_left      <= 1'b0;
         brain_right     <= 1'b0;
         pkt_ok          <= 1'b0;
         pkt_err         <= 1'b0;
      end else begin
         pkt_ok      <= 1'b0;
         pkt_err     <= 1'b0;
         brain_left  <= 1'b0;
         brain_right <= 1'b0;
         if (rx_valid) begin
            case (state)
               SYNC1: begin
                  if (rx_data == 8'hAA) state <= SYNC2;
               end
               SYNC2: begin
                  state <= (rx_data == 8'hAA) ? PLEN : SYNC1;
               end
               PLEN: begin
                  if (rx_data == 8'hAA) begin
                     state <= PLEN;
                  end else if (rx_data < 8'd170) begin
                     remaining <= rx_data;
                     sum       <= 8'd0;
                     v_att     <= 1'b0;
                     v_med     <= 1'b0;
                     v_sig     <= 1'b0;
                     state     <= (rx_data == 8'd0) ? CHK : CODE;
                  end else begin
                     pkt_err <= 1'b1;
                     state   <= SYNC1;
                  end
               end
               CODE: begin
                  sum       <= sum_next;
                  remaining <= rem_next;
                  code      <= rx_data;
                  // A code byte must leave room for at least one more byte.
                  if (rem_next == 8'd0) begin
                     pkt_err <= 1'b1;
                     state   <= SYNC1;
                  end else if (rx_data == 8'h55) begin
                     state <= CODE;
                  end else if (rx_data[7]) begin
                     state <= VLEN;
                  end else begin
                     vcount <= 8'd1;
                     state  <= VALUE;
                  end
               end
               VLEN: begin
                  sum       <= sum_next;
                  remaining <= rem_next;
                  vcount    <= rx_data;
                  if (rx_data > rem_next) begin
                     pkt_err <= 1'b1;
                     state   <= SYNC1;
                  end else if (rx_data == 8'd0) begin
                     state <= (rem_next == 8'd0) ? CHK : CODE;
                  end else begin
                     state <= VALUE;
                  end
               end
               VALUE: begin
                  sum       <= sum_next;
                  remaining <= rem_next;
                  vcount    <= vcount_next;
                  case (code)
                     8'h02: begin sh_sig <= rx_data; v_sig <= 1'b1; end
                     8'h04: begin sh_att <= rx_data; v_att <= 1'b1; end
                     8'h05: begin sh_med <= rx_data; v_med <= 1'b1; end
                     default: ;
                  endcase
                  if (vcount_next == 8'd0)
                     state <= (rem_next == 8'd0) ? CHK : CODE;
               end
               CHK: begin
                  if (rx_data == ~sum) begin
                     pkt_ok          <= 1'b1;
                     attention_data  <= att_commit;
                     meditation_data <= med_commit;
                     signal_data     <= sig_commit;
                     brain_right     <= steer_right;
                     brain_left      <= steer_left;
                  end else begin
                     pkt_err <= 1'b1;
                  end
                  state <= SYNC1;
               end
               default: state <= SYNC1;
            endcase
         end
      end
   end

endmodule
